// File: rtl/mem_fetch_unit_pkg.sv
// Shared CPU definitions: word/address widths and fetch FSM encoding.
// Reused by the control unit and the memory fetch unit.
package mem_fetch_unit_pkg;

    localparam int CPU_DATA_WIDTH = 16;
    localparam int CPU_ADDR_WIDTH = 16;
    localparam int TIMER_WIDTH    = 8;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WAIT0 = 3'd1;
    localparam logic [2:0] ST_WAIT1 = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_ERR   = 3'd4;

    function automatic logic is_wait(input logic [2:0] st);
        return (st == ST_WAIT0) || (st == ST_WAIT1);
    endfunction

endpackage

// File: rtl/mem_fetch_unit_wait_timer.sv
// Per-word wait counter for the fetch unit.
// expired is high on the TIMEOUT-th waiting cycle.
module fetch_wait_timer
    import mem_fetch_unit_pkg::*;
#(
    parameter int TIMEOUT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [TIMER_WIDTH-1:0] count;

    assign expired = (count == TIMER_WIDTH'(TIMEOUT - 1));

    // Count waiting cycles; hold at the expiry value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + TIMER_WIDTH'(1);
        end
    end

endmodule

// File: rtl/mem_fetch_unit.sv
// Fetches one or two words (opcode plus immediate) from memory,
// with a bounded wait per word and a sticky timeout flag.
module mem_fetch_unit
    import mem_fetch_unit_pkg::*;
#(
    parameter int DATA_WIDTH = CPU_DATA_WIDTH,
    parameter int ADDR_WIDTH = CPU_ADDR_WIDTH,
    parameter int TIMEOUT    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  req_len,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  timeout_err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_req,
    input  logic [DATA_WIDTH-1:0] mem_data,
    input  logic                  mem_ready
);

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic       len_q;
    logic       waiting;
    logic       accept;
    logic       take0;
    logic       take1;
    logic       expired;
    logic       timer_clear;
    logic       timer_en;
    logic       give_up;

    assign waiting = is_wait(state);
    assign accept  = (state == ST_IDLE) && req;
    assign take0   = (state == ST_WAIT0) && mem_ready;
    assign take1   = (state == ST_WAIT1) && mem_ready;
    assign give_up = waiting && !mem_ready && expired;

    // Counter restarts outside the wait states and between words.
    assign timer_clear = !waiting || take0;
    assign timer_en    = waiting && !mem_ready;

    assign busy    = (state != ST_IDLE);
    assign done    = (state == ST_DONE);
    assign mem_req = waiting;

    fetch_wait_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (timer_clear),
        .enable (timer_en),
        .expired(expired)
    );

    // Next-state logic; ready wins over an expiring wait.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (req) state_nxt = ST_WAIT0;
            end
            ST_WAIT0: begin
                if (mem_ready) state_nxt = len_q ? ST_WAIT1 : ST_DONE;
                else if (expired) state_nxt = ST_ERR;
            end
            ST_WAIT1: begin
                if (mem_ready) state_nxt = ST_DONE;
                else if (expired) state_nxt = ST_ERR;
            end
            ST_DONE: state_nxt = ST_IDLE;
            ST_ERR:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Request latch, address sequencing, data capture and error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q       <= 1'b0;
            mem_addr    <= '0;
            rdata0      <= '0;
            rdata1      <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (accept) begin
                len_q       <= req_len;
                mem_addr    <= req_addr;
                timeout_err <= 1'b0;
                if (!req_len) rdata1 <= '0;
            end
            if (take0) begin
                rdata0 <= mem_data;
                if (len_q) mem_addr <= mem_addr + ADDR_WIDTH'(1);
            end
            if (take1) begin
                rdata1 <= mem_data;
            end
            if (give_up) begin
                timeout_err <= 1'b1;
            end
        end
    end

endmodule
